// File: rtl/fir_pkg.sv
// fir_pkg: register map, ap_ctrl bit positions and
// engine FSM states shared by the fir_filter slice.
package fir_pkg;

  localparam int ADDR_CTRL = 'h00;
  localparam int ADDR_LEN  = 'h10;
  localparam int ADDR_TAP  = 'h20;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DONE    = 1;
  localparam int CTRL_IDLE    = 2;
  localparam int CTRL_IN_RDY  = 4;
  localparam int CTRL_OUT_VLD = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_CALC,
    S_OUT
  } state_t;

endpackage

// File: rtl/fir_axil.sv
// fir_axil: AXI-Lite slave, ap_ctrl/data_length registers
// and tap SRAM arbitration (host owns it only while idle).
module fir_axil
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_awvalid,
  input  logic [pADDR_WIDTH-1:0] i_awaddr,
  output logic                   o_awready,
  input  logic                   i_wvalid,
  input  logic [pDATA_WIDTH-1:0] i_wdata,
  output logic                   o_wready,
  input  logic                   i_arvalid,
  input  logic [pADDR_WIDTH-1:0] i_araddr,
  output logic                   o_arready,
  input  logic                   i_rready,
  output logic                   o_rvalid,
  output logic [pDATA_WIDTH-1:0] o_rdata,
  input  logic                   i_idle,
  input  logic                   i_done_set,
  input  logic [1:0]             i_ext,
  output logic                   o_start,
  output logic [pDATA_WIDTH-1:0] o_len,
  input  logic                   i_eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] i_eng_tap_A,
  output logic [3:0]             o_tap_WE,
  output logic                   o_tap_EN,
  output logic [pDATA_WIDTH-1:0] o_tap_Di,
  output logic [pADDR_WIDTH-1:0] o_tap_A,
  input  logic [pDATA_WIDTH-1:0] i_tap_Do
);

  localparam int A = pADDR_WIDTH;
  localparam logic [A-1:0] LP_CTRL = A'(ADDR_CTRL);
  localparam logic [A-1:0] LP_LEN  = A'(ADDR_LEN);
  localparam logic [A-1:0] LP_TLO  = A'(ADDR_TAP);
  localparam logic [A-1:0] LP_THI  =
    A'(ADDR_TAP + 4 * Tape_Num);

  logic                   r_arready;
  logic                   r_wr_rdy;
  logic                   r_rvalid;
  logic                   r_rd_live;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic                   r_start;
  logic                   r_done;
  logic [pDATA_WIDTH-1:0] r_len;

  logic                   w_rd_tap;
  logic                   w_wr_tap;
  logic                   w_rd_hs;
  logic                   w_wr_hs;
  logic                   w_rd_sram;
  logic                   w_wr_sram;
  logic                   w_wr_ctrl;
  logic                   w_wr_len;
  logic                   w_go;
  logic [pDATA_WIDTH-1:0] w_ctrl;
  logic [pDATA_WIDTH-1:0] w_rd_val;

  assign w_rd_tap = (i_araddr >= LP_TLO) &&
                    (i_araddr < LP_THI) &&
                    (i_araddr[1:0] == 2'b00);
  assign w_wr_tap = (i_awaddr >= LP_TLO) &&
                    (i_awaddr < LP_THI) &&
                    (i_awaddr[1:0] == 2'b00);

  assign w_rd_hs   = i_arvalid && r_arready;
  assign w_wr_hs   = i_awvalid && i_wvalid && r_wr_rdy;
  assign w_rd_sram = w_rd_hs && w_rd_tap && i_idle;
  assign w_wr_sram = w_wr_hs && w_wr_tap && i_idle;
  assign w_wr_ctrl = w_wr_hs && (i_awaddr == LP_CTRL);
  assign w_wr_len  = w_wr_hs && (i_awaddr == LP_LEN);
  assign w_go      = w_wr_ctrl && i_idle &&
                     i_wdata[CTRL_START];

  assign o_awready = r_wr_rdy;
  assign o_wready  = r_wr_rdy;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rd_live ? i_tap_Do : r_rdata;
  assign o_start   = r_start;
  assign o_len     = r_len;

  // Single-cycle ready pulses; a pending read blocks writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arready <= 1'b0;
      r_wr_rdy  <= 1'b0;
    end else begin
      r_arready <= i_arvalid && !r_arready &&
                   !r_rvalid && !r_wr_rdy;
      r_wr_rdy  <= i_awvalid && i_wvalid &&
                   !r_wr_rdy && !i_arvalid &&
                   !r_arready && !r_rvalid;
    end
  end

  // Read response; SRAM data is latched after its 1-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid  <= 1'b0;
      r_rd_live <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_live <= w_rd_sram;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else begin
        if (r_rvalid && i_rready) r_rvalid <= 1'b0;
        if (r_rd_live) r_rdata <= i_tap_Do;
      end
    end
  end

  // ap_ctrl start/done bits and data_length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_len   <= '0;
    end else begin
      if (!i_idle) r_start <= 1'b0;
      else if (w_go) r_start <= 1'b1;
      if (i_done_set) r_done <= 1'b1;
      else if (w_go) r_done <= 1'b0;
      if (w_wr_len) r_len <= i_wdata;
    end
  end

  // ap_ctrl read image
  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_START]   = r_start;
    w_ctrl[CTRL_DONE]    = r_done;
    w_ctrl[CTRL_IDLE]    = i_idle;
    w_ctrl[CTRL_IN_RDY]  = i_ext[0];
    w_ctrl[CTRL_OUT_VLD] = i_ext[1];
  end

  // Read value captured at address handshake
  always_comb begin
    w_rd_val = '0;
    if (w_rd_tap) w_rd_val = i_idle ? '0 : '1;
    else if (i_araddr == LP_CTRL) w_rd_val = w_ctrl;
    else if (i_araddr == LP_LEN) w_rd_val = r_len;
  end

  // Tap SRAM port: host while idle, engine otherwise
  always_comb begin
    o_tap_WE = 4'h0;
    o_tap_EN = 1'b0;
    o_tap_Di = '0;
    o_tap_A  = '0;
    if (i_idle) begin
      o_tap_EN = w_rd_sram || w_wr_sram;
      o_tap_WE = w_wr_sram ? 4'hF : 4'h0;
      o_tap_Di = i_wdata;
      o_tap_A  = w_rd_sram ? (i_araddr - LP_TLO)
                           : (i_awaddr - LP_TLO);
    end else begin
      o_tap_EN = i_eng_tap_EN;
      o_tap_A  = i_eng_tap_A;
    end
  end

endmodule

// File: rtl/fir_filter.sv
// fir_filter: single-MAC FIR engine over external tap/data SRAMs.
// FIR_STATUS_EXT_EN exposes input-ready/output-valid in ap_ctrl.
module fir_filter
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   awready,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arready,
  input  logic                   rready,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic [31:0]            ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [31:0]            sm_tdata,
  output logic                   sm_tlast,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam int CW = $clog2(Tape_Num + 1);
  localparam int IW = $clog2(Tape_Num);
  localparam logic [IW-1:0] LP_LAST = IW'(Tape_Num - 1);
  localparam logic [CW-1:0] LP_KMAX = CW'(Tape_Num);
  localparam logic [CW-1:0] LP_CEND = CW'(Tape_Num - 1);

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_head;
  logic [IW-1:0]          r_didx;
  logic                   r_mac;
  logic [31:0]            r_acc;
  logic [31:0]            r_y;
  logic [pDATA_WIDTH-1:0] r_ocnt;

  logic                   w_idle;
  logic                   w_start;
  logic [pDATA_WIDTH-1:0] w_len;
  logic [1:0]             w_ext;
  logic                   w_sm_hs;
  logic                   w_last;
  logic                   w_done;
  logic                   w_rd;
  logic [IW-1:0]          w_nhead;
  logic [31:0]            w_prod;
  logic [pADDR_WIDTH-1:0] w_eng_tap_A;
  logic                   w_unused_tlast;

  assign w_unused_tlast = ss_tlast;

  assign w_idle    = (r_state == S_IDLE);
  assign ss_tready = (r_state == S_WAIT_IN) && ss_tvalid;
  assign sm_tvalid = (r_state == S_OUT);
  assign sm_tdata  = r_y;
  assign w_last    = (r_ocnt + pDATA_WIDTH'(1)) == w_len;
  assign sm_tlast  = sm_tvalid && w_last;
  assign w_sm_hs   = sm_tvalid && sm_tready;
  assign w_done    = w_sm_hs && w_last;
  assign w_rd      = (r_state == S_CALC) &&
                     (r_cnt < LP_KMAX);
  assign w_nhead   = (r_head == LP_LAST) ? '0
                   : r_head + IW'(1);
  assign w_prod    = 32'(tap_Do * data_Do);
  assign w_eng_tap_A = pADDR_WIDTH'({r_cnt, 2'b00});

`ifdef FIR_STATUS_EXT_EN
  assign w_ext = {sm_tvalid, r_state == S_WAIT_IN};
`else
  assign w_ext = 2'b00;
`endif

  fir_axil #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .Tape_Num    (Tape_Num)
  ) u_axil (
    .clk          (axis_clk),
    .rst_n        (axis_rst_n),
    .i_awvalid    (awvalid),
    .i_awaddr     (awaddr),
    .o_awready    (awready),
    .i_wvalid     (wvalid),
    .i_wdata      (wdata),
    .o_wready     (wready),
    .i_arvalid    (arvalid),
    .i_araddr     (araddr),
    .o_arready    (arready),
    .i_rready     (rready),
    .o_rvalid     (rvalid),
    .o_rdata      (rdata),
    .i_idle       (w_idle),
    .i_done_set   (w_done),
    .i_ext        (w_ext),
    .o_start      (w_start),
    .o_len        (w_len),
    .i_eng_tap_EN (w_rd),
    .i_eng_tap_A  (w_eng_tap_A),
    .o_tap_WE     (tap_WE),
    .o_tap_EN     (tap_EN),
    .o_tap_Di     (tap_Di),
    .o_tap_A      (tap_A),
    .i_tap_Do     (tap_Do)
  );

  // Engine FSM: clear, take sample, MAC over taps, emit
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_head  <= '0;
      r_didx  <= '0;
      r_mac   <= 1'b0;
      r_acc   <= '0;
      r_y     <= '0;
      r_ocnt  <= '0;
    end else begin
      r_mac <= w_rd;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LP_CEND) begin
            r_state <= S_WAIT_IN;
            r_head  <= LP_LAST;
            r_ocnt  <= '0;
          end
        end
        S_WAIT_IN: begin
          if (ss_tready) begin
            r_state <= S_CALC;
            r_head  <= w_nhead;
            r_didx  <= w_nhead;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + CW'(1);
          r_didx <= (r_didx == '0) ? LP_LAST
                  : r_didx - IW'(1);
          if (r_mac) r_acc <= r_acc + w_prod;
          if (r_cnt == LP_KMAX) begin
            r_y     <= r_acc + w_prod;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (w_sm_hs) begin
            r_ocnt  <= r_ocnt + pDATA_WIDTH'(1);
            r_state <= w_last ? S_IDLE : S_WAIT_IN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data SRAM port: clear writes, sample write, MAC reads
  always_comb begin
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_Di = '0;
    data_A  = '0;
    if (r_state == S_CLEAR) begin
      data_EN = 1'b1;
      data_WE = 4'hF;
      data_A  = pADDR_WIDTH'({r_cnt, 2'b00});
    end else if (ss_tready) begin
      data_EN = 1'b1;
      data_WE = 4'hF;
      data_Di = pDATA_WIDTH'(ss_tdata);
      data_A  = pADDR_WIDTH'({w_nhead, 2'b00});
    end else if (w_rd) begin
      data_EN = 1'b1;
      data_A  = pADDR_WIDTH'({r_didx, 2'b00});
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: randomized scoreboard bench for fir_filter
// with behavioural tap/data SRAMs and a convolution model.
module tb_fir_filter;

  localparam int N = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0;
  logic [11:0] awaddr = '0;
  logic        awready;
  logic        wvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic        wready;
  logic        arvalid = 1'b0;
  logic [11:0] araddr = '0;
  logic        arready;
  logic        rready = 1'b0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ss_tvalid = 1'b0;
  logic [31:0] ss_tdata = '0;
  logic        ss_tlast = 1'b0;
  logic        ss_tready;
  logic        sm_tready = 1'b1;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic [3:0]  data_WE;
  logic        data_EN;
  logic [31:0] data_Di;
  logic [11:0] data_A;
  logic [31:0] data_Do;

  fir_filter dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .awvalid    (awvalid),
    .awaddr     (awaddr),
    .awready    (awready),
    .wvalid     (wvalid),
    .wdata      (wdata),
    .wready     (wready),
    .arvalid    (arvalid),
    .araddr     (araddr),
    .arready    (arready),
    .rready     (rready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .ss_tready  (ss_tready),
    .sm_tready  (sm_tready),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_Di     (tap_Di),
    .tap_A      (tap_A),
    .tap_Do     (tap_Do),
    .data_WE    (data_WE),
    .data_EN    (data_EN),
    .data_Di    (data_Di),
    .data_A     (data_A),
    .data_Do    (data_Do)
  );

  always #5 clk = ~clk;

  logic [31:0] tap_mem [1024];
  logic [31:0] data_mem [1024];

  always @(posedge clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b])
          tap_mem[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= tap_mem[tap_A[11:2]];
    end
    if (data_EN) begin
      for (int b = 0; b < 4; b++)
        if (data_WE[b])
          data_mem[data_A[11:2]][8*b +: 8] <= data_Di[8*b +: 8];
      data_Do <= data_mem[data_A[11:2]];
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_hs = -1000;
  bit   rnd_rdy = 1'b0;
  int   coef [N] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int   hist [$];
  int   samp [600];
  exp_t sbq [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int model_y();
    int acc = 0;
    int n = hist.size();
    for (int k = 0; k < N; k++)
      if (k < n) acc += coef[k] * hist[n - 1 - k];
    return acc;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pop expected at each output handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sm_tvalid && sm_tready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_out: got %h want none", sm_tdata);
      end else begin
        e = sbq.pop_front();
        chk("y", sm_tdata, e.d);
        chk("tlast", {31'd0, sm_tlast}, {31'd0, e.l});
      end
    end
  end

  // Input monitor: sample spacing never below N+3 cycles
  initial forever begin
    @(negedge clk);
    #1;
    if (ss_tvalid && ss_tready) begin
      chk("ss_gap", {31'd0, (cyc - last_hs) >= N + 3}, 32'd1);
      last_hs = cyc;
    end
  end

  // Output backpressure generator
  initial forever begin
    @(posedge clk);
    #1;
    sm_tready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic axil_write(input logic [11:0] a,
                            input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    awvalid = 1'b1;
    wvalid  = 1'b1;
    awaddr  = a;
    wdata   = d;
    while (!awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!awready) begin
      total++;
      bad++;
      $display("FAIL wr_timeout: got no awready want awready");
    end else begin
      @(posedge clk);
    end
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic axil_read(input logic [11:0] a,
                           output logic [31:0] d);
    int n = 0;
    d = '0;
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = a;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      total++;
      bad++;
      $display("FAIL rd_timeout: got no arready want arready");
      arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) begin
      total++;
      bad++;
      $display("FAIL rvalid_timeout: got 0 want 1");
    end else begin
      d = rdata;
      @(posedge clk);
    end
    #1;
    rready = 1'b0;
  endtask

  // kind: 0 impulse, 1 fresh random, 2 replay of last random
  task automatic run_stream(input int n, input int kind);
    int   w;
    int   x;
    exp_t e;
    hist.delete();
    for (int i = 0; i < n; i++) begin
      if (kind == 0) x = (i == 0) ? 1 : 0;
      else if (kind == 1) begin
        x = (i % 3 == 0) ? int'($urandom)
          : $urandom_range(0, 2000) - 1000;
        samp[i] = x;
      end else x = samp[i];
      hist.push_back(x);
      e.d = model_y();
      e.l = (i == n - 1);
      sbq.push_back(e);
      @(negedge clk);
      ss_tvalid = 1'b1;
      ss_tdata  = x;
      ss_tlast  = (i == n - 1);
      #1;
      w = 0;
      while (!ss_tready && w < 400) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (!ss_tready) begin
        total++;
        bad++;
        $display("FAIL ss_timeout: got no ss_tready want ready");
        ss_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      ss_tvalid = 1'b0;
      ss_tlast  = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  logic [31:0] v;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sm_tvalid", {31'd0, sm_tvalid}, 0);
    chk("rst_ss_tready", {31'd0, ss_tready}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_awready", {31'd0, awready}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_sm_tdata", sm_tdata, 0);
    chk("rst_sram_en", {30'd0, tap_EN, data_EN}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    axil_read(12'h000, v);
    chk("ctrl_reset", v, 32'h4);
    axil_read(12'h010, v);
    chk("len_reset", v, 0);
    axil_write(12'h004, 32'hDEAD);
    axil_read(12'h004, v);
    chk("unmapped", v, 0);

    for (int k = 0; k < N; k++)
      axil_write(12'(32'h20 + 4 * k), 32'(coef[k]));
    for (int k = 0; k < N; k++) begin
      axil_read(12'(32'h20 + 4 * k), v);
      chk($sformatf("tap%0d", k), v, 32'(coef[k]));
    end

    axil_write(12'h010, 32'd11);
    axil_read(12'h010, v);
    chk("len_rb", v, 32'd11);
    axil_write(12'h000, 32'h1);
    fork
      run_stream(11, 0);
      begin
        repeat (25) @(negedge clk);
        axil_read(12'h000, v);
        chk("ctrl_busy", v & 32'hF, 0);
      end
    join
    wait_drain();
    repeat (4) @(negedge clk);
    axil_read(12'h000, v);
    chk("ctrl_done", v & 32'h7, 32'h6);

    rnd_rdy = 1'b1;
    axil_write(12'h010, 32'd600);
    axil_write(12'h000, 32'h1);
    fork
      run_stream(600, 1);
      begin
        repeat (60) @(negedge clk);
        axil_read(12'h000, v);
        chk("ctrl_busy2", v & 32'hF, 0);
        axil_write(12'h020, 32'd5);
        axil_read(12'h020, v);
        chk("tap_busy_rd", v, 32'hFFFF_FFFF);
      end
    join
    wait_drain();
    repeat (4) @(negedge clk);
    axil_read(12'h000, v);
    chk("ctrl_done2", v & 32'h7, 32'h6);
    axil_read(12'h020, v);
    chk("tap0_kept", v, 0);

    axil_write(12'h000, 32'h1);
    run_stream(600, 2);
    wait_drain();
    repeat (4) @(negedge clk);
    axil_read(12'h000, v);
    chk("ctrl_done3", v & 32'h7, 32'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
